barrier_sequencer: RTL

BARRIER_SEQUENCER -- requirements
Module: barrier_sequencer

---
 rtl/barrier_pkg.sv | 19 +
 rtl/barrier_lfsr.sv | 21 ++
 rtl/barrier_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/barrier_pkg.sv
// Shared definitions for the barrier sequencer: FSM state encoding,
// LFSR seed/taps and the score saturation limit.
package barrier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GAP      = 3'd1,
    ST_APPROACH = 3'd2,
    ST_ARMED    = 3'd3,
    ST_RETIRE   = 3'd4
  } state_t;

  // Fibonacci LFSR, taps at bits 16,14,13,11 (1-based) -> mask bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;

endpackage

// File: rtl/barrier_lfsr.sv
// 16-bit Fibonacci LFSR used to randomise the gap between barriers.
// Only instantiated when BARRIER_RANDOM_GAP_EN is defined.
module barrier_lfsr
  import barrier_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  // Shift once per advance pulse; feedback is the XOR of the tapped bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/barrier_sequencer.sv
// Barrier game sequencer: spaces barriers in time, arms them when the
// sprite is in position, detects player overlap, and keeps lives/score.
// Optional macro BARRIER_RANDOM_GAP_EN adds an LFSR-randomised gap.
module barrier_sequencer
  import barrier_pkg::*;
#(
  parameter int GAP_MIN_FRAMES      = 30,
  parameter int ARM_FRAMES          = 8,
  parameter int APPROACH_MAX_FRAMES = 64,
  parameter int LIVES_INIT          = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_v_sync,
  input  logic        i_start,
  input  logic        i_game_run,
  input  logic        i_barrier_hit,
  input  logic        i_player_hit,
  input  logic        i_in_position,
  output logic        o_active,
  output logic        o_collision,
  output logic [1:0]  o_lives,
  output logic [15:0] o_score,
  output logic        o_game_over
);

  state_t      state;
  logic        v_sync_q;
  logic        frame_tick;
  logic [15:0] gap_cnt;
  logic [15:0] arm_cnt;
  logic [15:0] appr_cnt;
  logic        overlap;
  logic        overlap_now;
  logic [15:0] gap_load;

  function automatic logic [15:0] score_inc(input logic [15:0] s);
    return (s == SCORE_MAX) ? s : s + 16'd1;
  endfunction

  function automatic logic [1:0] lives_dec(input logic [1:0] l);
    return (l == 2'd0) ? l : l - 2'd1;
  endfunction

`ifdef BARRIER_RANDOM_GAP_EN
  logic [15:0] lfsr_value;

  barrier_lfsr u_lfsr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .advance (frame_tick),
    .value   (lfsr_value)
  );

  assign gap_load = 16'(GAP_MIN_FRAMES) + {11'd0, lfsr_value[4:0]};
`else
  assign gap_load = 16'(GAP_MIN_FRAMES);
`endif

  // An overlap in the same cycle as the frame tick still counts
  assign overlap_now = overlap | (i_barrier_hit & i_player_hit);

  // Rising-edge detect on v_sync, registered so the tick lands one cycle after the edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_sync_q   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      v_sync_q   <= i_v_sync;
      frame_tick <= i_v_sync & ~v_sync_q;
    end
  end

  // Game FSM with lives, score and frame counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_active    <= 1'b0;
      o_collision <= 1'b0;
      o_lives     <= 2'(LIVES_INIT);
      o_score     <= 16'd0;
      o_game_over <= 1'b0;
      gap_cnt     <= 16'd0;
      arm_cnt     <= 16'd0;
      appr_cnt    <= 16'd0;
      overlap     <= 1'b0;
    end else begin
      o_collision <= 1'b0;
      if (!i_game_run) begin
        // Pause drops straight to IDLE; lives and score are kept
        state    <= ST_IDLE;
        o_active <= 1'b0;
        overlap  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              o_lives     <= 2'(LIVES_INIT);
              o_score     <= 16'd0;
              o_game_over <= 1'b0;
              gap_cnt     <= gap_load;
              state       <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (frame_tick) begin
              if (gap_cnt <= 16'd1) begin
                state    <= ST_APPROACH;
                o_active <= 1'b1;
                gap_cnt  <= 16'd0;
                appr_cnt <= 16'd0;
              end else begin
                gap_cnt <= gap_cnt - 16'd1;
              end
            end
          end
          ST_APPROACH: begin
            if (frame_tick) begin
              if (i_in_position) begin
                state   <= ST_ARMED;
                arm_cnt <= 16'(ARM_FRAMES);
                overlap <= 1'b0;
              end else if ((appr_cnt + 16'd1) >= 16'(APPROACH_MAX_FRAMES)) begin
                // Barrier never reached position: retire without scoring
                state    <= ST_RETIRE;
                o_active <= 1'b0;
                appr_cnt <= 16'd0;
              end else begin
                appr_cnt <= appr_cnt + 16'd1;
              end
            end
          end
          ST_ARMED: begin
            if (frame_tick) begin
              overlap <= 1'b0;
              if (overlap_now) begin
                o_collision <= 1'b1;
                o_lives     <= lives_dec(o_lives);
                if (o_lives == 2'd1) begin
                  o_game_over <= 1'b1;
                end
                state    <= ST_RETIRE;
                o_active <= 1'b0;
                arm_cnt  <= 16'd0;
              end else if (arm_cnt <= 16'd1) begin
                o_score  <= score_inc(o_score);
                state    <= ST_RETIRE;
                o_active <= 1'b0;
                arm_cnt  <= 16'd0;
              end else begin
                arm_cnt <= arm_cnt - 16'd1;
              end
            end else begin
              overlap <= overlap_now;
            end
          end
          ST_RETIRE: begin
            // Hold inactive for one frame so the sprite resets on a v_sync edge
            if (frame_tick) begin
              if (o_game_over) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= gap_load;
              end
            end
          end
          default: begin
            state    <= ST_IDLE;
            o_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
